// File: rtl/aes_ctr_scheduler_pkg.sv
// Shared widths, defaults and FSM state type for the AES-CTR keystream scheduler.
package aes_ctr_scheduler_pkg;

  localparam int unsigned BLK_W     = 128;
  localparam int unsigned NONCE_W   = 96;
  localparam int unsigned CTR_W     = 32;
  localparam int unsigned DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

endpackage

// File: rtl/aes_ctr_scheduler_sync_fifo.sv
// Synchronous FIFO with registered storage, first-word read and an occupancy count.
module sync_fifo #(
  parameter int unsigned WIDTH = 128,
  parameter int unsigned DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push_i,
  input  logic [WIDTH-1:0]       data_i,
  input  logic                   pop_i,
  output logic [WIDTH-1:0]       data_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned CNT_W = AW + 1;
  localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             full, do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is only accepted when a pop frees the slot in the same cycle.
  assign do_push = push_i && (!full || do_pop);
  assign count_o = count_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // NOTE: storage is deliberately not reset; the empty gate on data_o hides stale words.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full && !pop_i));

endmodule

// File: rtl/aes_ctr_scheduler.sv
// Issues {nonce,ctr} blocks to a pipelined AES core under a credit limit and buffers keystream.
module aes_ctr_scheduler
  import aes_ctr_scheduler_pkg::*;
#(
  parameter int unsigned DEPTH   = DEPTH_DEF,
  parameter int unsigned AES_LAT = 21
) (
  input  logic               CLK,
  input  logic               RSTn,
  input  logic               start,
  input  logic [BLK_W-1:0]   key,
  input  logic [NONCE_W-1:0] nonce,
  input  logic [CTR_W-1:0]   ctr0,
  input  logic [CTR_W-1:0]   n_blocks,
  output logic               busy,
  output logic               done,
  output logic               err,
  output logic [BLK_W-1:0]   aes_kin,
  output logic [BLK_W-1:0]   aes_din,
  output logic               aes_drdy,
  input  logic [BLK_W-1:0]   aes_dout,
  input  logic               aes_dvld,
  output logic [BLK_W-1:0]   out_data,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

  state_e             state_q, state_d;
  logic [BLK_W-1:0]   key_q, key_d;
  logic [NONCE_W-1:0] nonce_q, nonce_d;
  logic [CTR_W-1:0]   ctr_q, ctr_d;
  logic [CTR_W-1:0]   rem_q, rem_d;
  logic [CW-1:0]      inflight_q, inflight_d;
  logic               zero_done_q, zero_done_d;
  logic               err_q, err_d;

  logic               issue, drain_fin, spurious, dvld_ok, credit_ok, fifo_empty;
  logic [CW-1:0]      fifo_count;

  // A result with nothing outstanding is dropped and flagged rather than buffered.
  assign spurious  = aes_dvld && (inflight_q == '0);
  assign dvld_ok   = aes_dvld && !spurious;
  assign credit_ok = ({1'b0, inflight_q} + {1'b0, fifo_count}) < DEPTH_W;

  always_comb begin
    // NOTE: every combinational output is defaulted first so no path can infer a latch.
    state_d     = state_q;
    key_d       = key_q;
    nonce_d     = nonce_q;
    ctr_d       = ctr_q;
    rem_d       = rem_q;
    zero_done_d = 1'b0;
    err_d       = err_q | spurious;
    issue       = 1'b0;
    drain_fin   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          key_d   = key;
          nonce_d = nonce;
          ctr_d   = ctr0;
          rem_d   = n_blocks;
          if (n_blocks == '0) zero_done_d = 1'b1;
          else                state_d     = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (credit_ok) begin
          issue = 1'b1;
          ctr_d = ctr_q + CTR_W'(1);
          rem_d = rem_q - CTR_W'(1);
          if (rem_q == CTR_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Completion is signalled while still in DRAIN, so a start in the done cycle is ignored.
        if (inflight_q == '0 && fifo_empty) begin
          drain_fin = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    inflight_d = inflight_q + CW'(issue) - CW'(dvld_ok);
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q     <= ST_IDLE;
      key_q       <= '0;
      nonce_q     <= '0;
      ctr_q       <= '0;
      rem_q       <= '0;
      inflight_q  <= '0;
      zero_done_q <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      key_q       <= key_d;
      nonce_q     <= nonce_d;
      ctr_q       <= ctr_d;
      rem_q       <= rem_d;
      inflight_q  <= inflight_d;
      zero_done_q <= zero_done_d;
      err_q       <= err_d;
    end
  end

  sync_fifo #(
    .WIDTH (BLK_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (CLK),
    .rst_n   (RSTn),
    .push_i  (dvld_ok),
    .data_i  (aes_dout),
    .pop_i   (out_ready),
    .data_o  (out_data),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  assign busy      = (state_q != ST_IDLE);
  assign done      = zero_done_q | drain_fin;
  assign err       = err_q;
  assign aes_kin   = key_q;
  assign aes_din   = {nonce_q, ctr_q};
  assign aes_drdy  = issue;
  assign out_valid = !fifo_empty;

  // A fixed-latency core can never hold more than AES_LAT blocks, and credit caps it at DEPTH.
  assert property (@(posedge CLK) disable iff (!RSTn)
    (32'(inflight_q) <= AES_LAT) && (32'(inflight_q) <= DEPTH));

endmodule

// File: tb/tb_aes_ctr_scheduler.sv
// Scoreboard bench: behavioural AES-128 core model, CTR reference model, decoupled output monitor.
module tb_aes_ctr_scheduler;
  import aes_ctr_scheduler_pkg::*;

  // DEPTH must exceed the issue-to-pop round trip (AES_LAT+1) for back-to-back issue.
  localparam int unsigned DEPTH   = 32;
  localparam int unsigned AES_LAT = 21;

  logic               CLK = 1'b0;
  logic               RSTn;
  logic               start;
  logic [BLK_W-1:0]   key;
  logic [NONCE_W-1:0] nonce;
  logic [CTR_W-1:0]   ctr0;
  logic [CTR_W-1:0]   n_blocks;
  logic               busy, done, err;
  logic [BLK_W-1:0]   aes_kin, aes_din, aes_dout, out_data;
  logic               aes_drdy, aes_dvld, out_valid, out_ready;

  always #5 CLK = ~CLK;

  aes_ctr_scheduler #(.DEPTH(DEPTH), .AES_LAT(AES_LAT)) dut (
    .CLK(CLK), .RSTn(RSTn), .start(start), .key(key), .nonce(nonce), .ctr0(ctr0),
    .n_blocks(n_blocks), .busy(busy), .done(done), .err(err), .aes_kin(aes_kin),
    .aes_din(aes_din), .aes_drdy(aes_drdy), .aes_dout(aes_dout), .aes_dvld(aes_dvld),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
  );

  // ---------------- AES-128 reference ----------------
  logic [7:0] sbox [256];

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x;
    p = 8'h00; x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [7:0] r;
    r = x;
    for (int i = 0; i < n; i++) r = {r[6:0], r[7]};
    return r;
  endfunction

  function automatic logic [7:0] sbox_calc(input logic [7:0] a);
    logic [7:0] inv;
    inv = 8'h01;
    for (int i = 0; i < 254; i++) inv = gmul(inv, a);
    return inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
  endfunction

  initial for (int i = 0; i < 256; i++) sbox[i] = sbox_calc(8'(i));

  function automatic logic [127:0] aes128(input logic [127:0] k, input logic [127:0] pt);
    logic [31:0]  w [44];
    logic [7:0]   s [16];
    logic [7:0]   t [16];
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [31:0]  tmp;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = k[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {tmp[23:0], tmp[31:24]};
        tmp = {sbox[tmp[31:24]], sbox[tmp[23:16]], sbox[tmp[15:8]], sbox[tmp[7:0]]} ^ {rc, 24'h0};
        rc  = xtime(rc);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int i = 0; i < 16; i++) s[i] = pt[127-8*i -: 8] ^ w[i/4][31-8*(i%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int i = 0; i < 16; i++) t[i] = sbox[s[i]];
      for (int c = 0; c < 4; c++)
        for (int rr = 0; rr < 4; rr++) s[rr+4*c] = t[rr + 4*((c+rr)%4)];
      if (r != 10) begin
        for (int c = 0; c < 4; c++) begin
          a0 = s[4*c]; a1 = s[4*c+1]; a2 = s[4*c+2]; a3 = s[4*c+3];
          s[4*c]   = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
          s[4*c+1] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
          s[4*c+2] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
          s[4*c+3] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
      end
      for (int i = 0; i < 16; i++) s[i] = s[i] ^ w[4*r + i/4][31-8*(i%4) -: 8];
    end
    for (int i = 0; i < 16; i++) res[127-8*i -: 8] = s[i];
    return res;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- AES core model: fixed latency, shares reset ----------------
  logic [127:0] pipe_d [AES_LAT];
  logic         pipe_v [AES_LAT];
  logic         inject_dvld;

  always @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      for (int i = 0; i < AES_LAT; i++) begin
        pipe_v[i] <= 1'b0;
        pipe_d[i] <= '0;
      end
    end else begin
      pipe_v[0] <= aes_drdy;
      pipe_d[0] <= aes_drdy ? aes128(aes_kin, aes_din) : '0;
      for (int i = 1; i < AES_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_d[i] <= pipe_d[i-1];
      end
    end
  end

  assign aes_dvld = pipe_v[AES_LAT-1] | inject_dvld;
  assign aes_dout = pipe_v[AES_LAT-1] ? pipe_d[AES_LAT-1] : 128'hdeadbeef_deadbeef_deadbeef_deadbeef;

  // ---------------- scoreboard and monitor ----------------
  int           n_checks = 0, n_fail = 0;
  logic [127:0] din_q [$];
  logic [127:0] exp_q [$];
  logic [127:0] cur_key = '0;
  int           cyc = 0, drdy_cnt = 0, out_cnt = 0, done_cnt = 0;
  int           first_issue = -1, last_issue = -1, first_valid = -1;
  bit           rand_ready = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic note_fail(input string name, input string what);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s (t=%0t)", name, what, $time);
  endtask

  always @(negedge CLK) begin
    cyc++;
    if (RSTn === 1'b1) begin
      if (aes_drdy) begin
        drdy_cnt++;
        if (first_issue < 0) first_issue = cyc;
        last_issue = cyc;
        if (din_q.size() == 0) note_fail("unexpected_issue", $sformatf("got aes_din=%0h, expected no issue", aes_din));
        else check("aes_din", aes_din, din_q.pop_front());
        check("aes_kin", aes_kin, cur_key);
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      if (out_valid && out_ready) begin
        out_cnt++;
        if (exp_q.size() == 0) note_fail("unexpected_output", $sformatf("got out_data=%0h, expected none", out_data));
        else check("out_data", out_data, exp_q.pop_front());
      end
      if (done) done_cnt++;
    end
  end

  always begin
    @(posedge CLK); #1;
    if (rand_ready) out_ready = 1'($urandom_range(0, 1));
  end

  // ---------------- stimulus helpers ----------------
  task automatic clear_stats();
    drdy_cnt = 0; out_cnt = 0;
    first_issue = -1; last_issue = -1; first_valid = -1;
  endtask

  task automatic start_job(input logic [127:0] k, input logic [95:0] nn, input logic [31:0] c0,
                           input logic [31:0] n, input bit kat_en, input logic [127:0] kat);
    logic [31:0] c;
    @(posedge CLK); #1;
    clear_stats();
    cur_key = k;
    for (int unsigned i = 0; i < n; i++) begin
      c = c0 + i;
      din_q.push_back({nn, c});
      exp_q.push_back(kat_en ? kat : aes128(k, {nn, c}));
    end
    key = k; nonce = nn; ctr0 = c0; n_blocks = n; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    int d0;
    bit seen;
    d0 = done_cnt;
    seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge CLK); #1;
      if (done_cnt != d0) seen = 1'b1;
    end
    if (!seen) note_fail(name, $sformatf("no done within %0d cycles, expected a done pulse", budget));
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int           d0, nrand;
    logic [127:0] k;
    logic [95:0]  nn;

    RSTn = 1'b0; start = 1'b0; key = '0; nonce = '0; ctr0 = '0; n_blocks = '0;
    out_ready = 1'b1; inject_dvld = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    check("rst_drdy", aes_drdy, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_aes_kin", aes_kin, 0);
    check("rst_aes_din", aes_din, 0);
    check("rst_out_data", out_data, 0);
    @(posedge CLK); #1; RSTn = 1'b1;

    // Known-answer block, first issue one cycle after start.
    start_job(128'h000102030405060708090a0b0c0d0e0f, 96'h00112233445566778899aabb, 32'hccddeeff,
              32'd1, 1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
    @(negedge CLK);
    check("kat_first_drdy", aes_drdy, 1);
    check("kat_busy", busy, 1);
    wait_done("kat_done", 100);
    check("kat_out_before_done", out_cnt, 1);

    // Counter wraps without touching the nonce.
    d0 = done_cnt;
    start_job(rand128(), rand128(), 32'hFFFFFFFF, 32'd3, 1'b0, '0);
    wait_done("wrap_done", 150);
    check("wrap_issues", drdy_cnt, 3);
    check("wrap_outputs", out_cnt, 3);
    repeat (5) @(negedge CLK);
    check("wrap_single_done", done_cnt - d0, 1);

    // Streaming at full rate.
    start_job(rand128(), rand128(), $urandom, 32'd100, 1'b0, '0);
    wait_done("stream_done", 400);
    check("stream_issues", drdy_cnt, 100);
    check("stream_back_to_back", last_issue - first_issue + 1, 100);
    check("stream_first_valid_lat", first_valid - first_issue, AES_LAT + 1);
    check("stream_outputs", out_cnt, 100);

    // Backpressure: credit stops issue at DEPTH outstanding.
    out_ready = 1'b0;
    start_job(rand128(), rand128(), $urandom, 32'd40, 1'b0, '0);
    repeat (200) @(negedge CLK);
    check("stall_issues", drdy_cnt, DEPTH);
    check("stall_out_valid", out_valid, 1);
    check("stall_err", err, 0);
    @(posedge CLK); #1; out_ready = 1'b1;
    wait_done("stall_done", 400);
    check("stall_outputs", out_cnt, 40);
    check("stall_issues_total", drdy_cnt, 40);

    // Zero-length job.
    d0 = done_cnt;
    start_job(rand128(), rand128(), $urandom, 32'd0, 1'b0, '0);
    @(negedge CLK);
    check("zero_done", done, 1);
    check("zero_drdy", aes_drdy, 0);
    check("zero_busy", busy, 0);
    @(negedge CLK);
    check("zero_done_pulse", done, 0);

    // Start while busy and start in the done cycle are both ignored.
    d0 = done_cnt;
    k = rand128(); nn = rand128();
    start_job(k, nn, $urandom, 32'd8, 1'b0, '0);
    @(posedge CLK); #1;
    key = rand128(); ctr0 = $urandom; n_blocks = 32'd3; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    wait_done("busy_start_done", 200);
    n_blocks = 32'd4; start = 1'b1;
    @(posedge CLK); #1;
    start = 1'b0;
    @(negedge CLK);
    check("done_cycle_start_busy", busy, 0);
    repeat (30) @(negedge CLK);
    check("busy_start_issues", drdy_cnt, 8);
    check("busy_start_one_done", done_cnt - d0, 1);

    // Randomised jobs under random backpressure.
    for (int j = 0; j < 3; j++) begin
      nrand = $urandom_range(1, 40);
      rand_ready = 1'b1;
      start_job(rand128(), rand128(), (j == 0) ? 32'hFFFFFFF0 : $urandom, 32'(nrand), 1'b0, '0);
      wait_done("rand_done", 300 + 8 * nrand);
      check("rand_outputs", out_cnt, nrand);
      rand_ready = 1'b0;
    end
    @(posedge CLK); #1; out_ready = 1'b1;

    // Result with nothing in flight: flagged, dropped, inflight unaffected.
    @(posedge CLK); #1; inject_dvld = 1'b1;
    @(posedge CLK); #1; inject_dvld = 1'b0;
    @(negedge CLK);
    check("spurious_err", err, 1);
    check("spurious_dropped", out_valid, 0);
    start_job(rand128(), rand128(), $urandom, 32'd2, 1'b0, '0);
    wait_done("post_spurious_done", 150);
    check("post_spurious_outputs", out_cnt, 2);
    check("err_sticky", err, 1);

    // Reset mid-job aborts without done.
    start_job(rand128(), rand128(), $urandom, 32'd20, 1'b0, '0);
    for (int i = 0; i < 100 && drdy_cnt < 5; i++) begin
      @(negedge CLK); #1;
    end
    if (drdy_cnt < 5) note_fail("abort_reach_block5", $sformatf("got %0d issues, expected 5", drdy_cnt));
    RSTn = 1'b0;
    din_q.delete();
    exp_q.delete();
    d0 = done_cnt;
    repeat (3) @(negedge CLK);
    check("abort_busy", busy, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_data", out_data, 0);
    check("abort_err_cleared", err, 0);
    @(posedge CLK); #1; RSTn = 1'b1;
    repeat (40) @(negedge CLK);
    check("abort_no_done", done_cnt - d0, 0);
    start_job(rand128(), rand128(), $urandom, 32'd2, 1'b0, '0);
    wait_done("after_abort_done", 150);
    check("after_abort_outputs", out_cnt, 2);
    check("after_abort_err", err, 0);
    check("queues_drained", din_q.size() + exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
